// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data-SRAM responder: bus widths, response payload and byte-lane merge.
package data_sram_responder_pkg;

  localparam int unsigned DSRAM_ADDR_WD = 14;
  localparam int unsigned DSRAM_DATA_WD = 32;
  localparam int unsigned DSRAM_STRB_WD = DSRAM_DATA_WD / 8;

  // One queued response; write responses carry a zero word.
  typedef struct packed {
    logic                     is_rd;
    logic [DSRAM_DATA_WD-1:0] word;
  } dsram_resp_t;

  // Width of the per-entry countdown that must hold LATENCY-1.
  function automatic int unsigned dsram_cnt_wd(input int unsigned latency);
    return $clog2(latency + 1);
  endfunction

  // Full response entry width: {is_rd, word, remaining}.
  function automatic int unsigned dsram_resp_wd(input int unsigned latency);
    return 1 + DSRAM_DATA_WD + dsram_cnt_wd(latency);
  endfunction

  function automatic logic [DSRAM_DATA_WD-1:0] dsram_merge(
    input logic [DSRAM_DATA_WD-1:0] old_w,
    input logic [DSRAM_DATA_WD-1:0] new_w,
    input logic [DSRAM_STRB_WD-1:0] strb
  );
    logic [DSRAM_DATA_WD-1:0] m;
    m = old_w;
    for (int i = 0; i < int'(DSRAM_STRB_WD); i++) begin
      if (strb[i]) m[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// In-order response queue: DEPTH-entry circular buffer where each entry counts down its
// remaining latency and becomes poppable at zero.
module sram_resp_fifo
  import data_sram_responder_pkg::*;
#(
  parameter  int unsigned DEPTH   = 2,
  parameter  int unsigned LATENCY = 1,
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  dsram_resp_t   i_ent,
  input  logic          i_pop,
  output logic [CW-1:0] o_count,
  output logic          o_head_ready_c,
  output dsram_resp_t   o_head_c
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned RW = dsram_cnt_wd(LATENCY);

  dsram_resp_t   r_ent [DEPTH];
  logic [RW-1:0] r_rem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Countdown runs on every slot; a fresh push overrides its slot's decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_rem[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (r_rem[i] != '0) r_rem[i] <= r_rem[i] - RW'(1);
      end
      if (i_push) begin
        r_ent[r_tail] <= i_ent;
        r_rem[r_tail] <= RW'(LATENCY - 1);
        r_tail        <= wrap_inc(r_tail);
      end
      if (i_pop) r_head <= wrap_inc(r_head);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count        = r_count;
  assign o_head_ready_c = (r_count != '0) && (r_rem[r_head] == '0);
  assign o_head_c       = r_ent[r_head];

endmodule

// File: rtl/data_sram_responder.sv
// Memory side of the CPU data-SRAM interface: word RAM with byte strobes, split req/addr_ok
// then data_ok/rdata handshake with fixed latency and in-order responses.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_WD = DSRAM_ADDR_WD,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     wr,
  input  logic [DSRAM_STRB_WD-1:0] wstrb,
  input  logic [31:0]              addr,
  input  logic [DSRAM_DATA_WD-1:0] wdata,
  output logic                     addr_ok,
  output logic                     data_ok,
  output logic [DSRAM_DATA_WD-1:0] rdata
);

  localparam int unsigned WORDS = 32'(1) << ADDR_WD;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic [DSRAM_DATA_WD-1:0] r_mem [WORDS];

  logic [ADDR_WD-1:0] w_idx;
  logic [CW-1:0]      w_count;
  logic               w_head_ready;
  logic               w_push;
  dsram_resp_t        w_head;
  dsram_resp_t        w_push_ent;
  logic               w_unused_addr;

  // Upper and byte-offset address bits alias onto the same word.
  assign w_idx         = addr[ADDR_WD+1:2];
  assign w_unused_addr = ^{addr[31:ADDR_WD+2], addr[1:0]};

  // A full queue still accepts when its head leaves this cycle.
  assign w_push  = req && ((w_count < CW'(DEPTH)) || w_head_ready);
  assign addr_ok = w_push;
  assign data_ok = w_head_ready;
  assign rdata   = (w_head_ready && w_head.is_rd) ? w_head.word : '0;

  always_ff @(posedge clk) begin
    if (!reset && w_push && wr) begin
      r_mem[w_idx] <= dsram_merge(r_mem[w_idx], wdata, wstrb);
    end
  end

  // Reads sample the word as committed by earlier edges.
  always_comb begin
    w_push_ent       = '0;
    w_push_ent.is_rd = !wr;
    if (!wr) w_push_ent.word = r_mem[w_idx];
  end

  sram_resp_fifo #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_resp_fifo (
    .clk            (clk),
    .reset          (reset),
    .i_push         (w_push),
    .i_ent          (w_push_ent),
    .i_pop          (w_head_ready),
    .o_count        (w_count),
    .o_head_ready_c (w_head_ready),
    .o_head_c       (w_head)
  );

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three configurations share one stimulus stream and are each
// compared every cycle against a queue-of-due-times reference model.
module tb_data_sram_responder;

  localparam int unsigned TB_AW = 8;

  logic        clk;
  logic        reset;
  logic        req;
  logic        wr;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok_v [3];
  logic        data_ok_v [3];
  logic [31:0] rdata_v   [3];

  int lat_k [3] = '{1, 3, 2};
  int dep_k [3] = '{2, 3, 1};

  int n_vec = 0;
  int n_bad = 0;

  data_sram_responder #(.ADDR_WD(TB_AW), .LATENCY(1), .DEPTH(2)) u_dut_a (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .wstrb(wstrb), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok_v[0]), .data_ok(data_ok_v[0]), .rdata(rdata_v[0]));

  data_sram_responder #(.ADDR_WD(TB_AW), .LATENCY(3), .DEPTH(3)) u_dut_b (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .wstrb(wstrb), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok_v[1]), .data_ok(data_ok_v[1]), .rdata(rdata_v[1]));

  data_sram_responder #(.ADDR_WD(TB_AW), .LATENCY(2), .DEPTH(1)) u_dut_c (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .wstrb(wstrb), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok_v[2]), .data_ok(data_ok_v[2]), .rdata(rdata_v[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) if (s[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  // Reference model: each instance keeps a queue of {kind, word, due cycle} and a word memory.
  typedef struct {
    bit          is_rd;
    bit          known;
    logic [31:0] word;
    int          due;
  } ent_t;

  ent_t        mq     [3][$];
  logic [31:0] mmem   [3][256];
  bit          mknown [3][256];
  bit          live   [3];
  int          cyc = 0;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin : per_inst
      bit          pop;
      bit          acc;
      int          idx;
      logic [31:0] exp_rd;
      ent_t        e;
      pop = (mq[k].size() > 0) && (mq[k][0].due == cyc);
      acc = req && ((mq[k].size() < dep_k[k]) || pop);
      idx = int'((addr >> 2) & ((32'd1 << TB_AW) - 32'd1));
      if (live[k]) begin
        chk($sformatf("addr_ok[%0d] cyc%0d", k, cyc), 32'(addr_ok_v[k]), 32'(acc));
        chk($sformatf("data_ok[%0d] cyc%0d", k, cyc), 32'(data_ok_v[k]), 32'(pop));
        exp_rd = (pop && mq[k][0].is_rd) ? mq[k][0].word : 32'h0;
        if (!(pop && mq[k][0].is_rd && !mq[k][0].known))
          chk($sformatf("rdata[%0d] cyc%0d", k, cyc), rdata_v[k], exp_rd);
      end
      if (reset) begin
        mq[k].delete();
        live[k] = 1'b1;
      end else if (live[k]) begin
        if (pop) void'(mq[k].pop_front());
        if (acc) begin
          e.due   = cyc + lat_k[k];
          e.is_rd = !wr;
          e.known = 1'b0;
          e.word  = 32'h0;
          if (wr) begin
            if (wstrb == 4'hF) mknown[k][idx] = 1'b1;
            mmem[k][idx] = (mmem[k][idx] & ~lane_mask(wstrb)) | (wdata & lane_mask(wstrb));
          end else begin
            e.known = mknown[k][idx];
            e.word  = mmem[k][idx];
          end
          mq[k].push_back(e);
        end
      end
    end
    cyc++;
  end

  task automatic drive(input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d);
    req = 1'b1; wr = w; wstrb = s; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; wr = 1'b0; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Lone read on an empty queue: checks latency and word on every instance.
  task automatic read_expect(input string tag, input logic [31:0] a, input logic [31:0] expv);
    int seen [3];
    seen = '{0, 0, 0};
    drive(1'b0, 4'h0, a, 32'h0);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (data_ok_v[k] && seen[k] == 0) begin
          seen[k] = j;
          chk($sformatf("%s rdata[%0d]", tag, k), rdata_v[k], expv);
        end
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s latency[%0d]", tag, k), 32'(seen[k]), 32'(lat_k[k]));
  endtask

  initial begin : watchdog
    #1000000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : stim
    int          cnt [3];
    logic [31:0] d;
    logic [31:0] a;
    req = 1'b0; wr = 1'b0; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0; reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst addr_ok[%0d]", k), 32'(addr_ok_v[k]), 32'h0);
      chk($sformatf("rst data_ok[%0d]", k), 32'(data_ok_v[k]), 32'h0);
      chk($sformatf("rst rdata[%0d]", k), rdata_v[k], 32'h0);
    end
    @(posedge clk); #1;

    // Preload words 0..15; two cycles each so every configuration accepts at least once.
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      drive(1'b1, 4'hF, 32'(w) << 2, d);
      drive(1'b1, 4'hF, 32'(w) << 2, d);
    end
    idle(5);

    drive(1'b1, 4'hF, 32'h10, 32'h11223344);
    idle(4);
    read_expect("full_wr", 32'h10, 32'h11223344);
    drive(1'b1, 4'b0100, 32'h10, 32'h00AA0000);
    idle(4);
    read_expect("lane2_wr", 32'h10, 32'h11AA3344);
    drive(1'b1, 4'h0, 32'h10, 32'hFFFFFFFF);
    idle(4);
    read_expect("zero_strb", 32'h10, 32'h11AA3344);

    // Six back-to-back reads of words 0..5.
    cnt = '{0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      req = 1'b1; wr = 1'b0; wstrb = 4'h0; addr = 32'(i) << 2; wdata = 32'h0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (addr_ok_v[k]) cnt[k]++;
      @(posedge clk); #1;
    end
    req = 1'b0; addr = 32'h0;
    chk("b2b accepts L1D2", 32'(cnt[0]), 32'd6);
    chk("b2b accepts L3D3", 32'(cnt[1]), 32'd6);
    chk("b2b accepts L2D1", 32'(cnt[2]), 32'd3);
    idle(6);

    // Read-after-write in consecutive cycles through an aliased address.
    drive(1'b1, 4'hF, 32'h20, 32'hDEADBEEF);
    drive(1'b0, 4'h0, 32'h20 + (32'h4 << TB_AW), 32'h0);
    idle(5);
    read_expect("alias_hi", 32'h20 + (32'h4 << TB_AW), 32'hDEADBEEF);
    read_expect("alias_lo", 32'h20, 32'hDEADBEEF);

    // Reset with reads outstanding drops their responses but keeps RAM contents.
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b0, 4'h0, 32'h4, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    cnt = '{0, 0, 0};
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (data_ok_v[k]) cnt[k]++;
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) chk($sformatf("post_rst data_ok[%0d]", k), 32'(cnt[k]), 32'h0);
    read_expect("post_rst", 32'h20, 32'hDEADBEEF);

    // Random traffic over a few words with aliased upper bits and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      a = $urandom;
      a[TB_AW+1:2] = TB_AW'($urandom_range(0, 15));
      req   = ($urandom_range(0, 9) < 7);
      wr    = 1'($urandom_range(0, 1));
      wstrb = 4'($urandom);
      addr  = a;
      wdata = $urandom;
      reset = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    reset = 1'b0; req = 1'b0; wr = 1'b0; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
